rs_pool: RTL and testbench

RS_POOL -- requirements
Module: rs_pool

---
 rtl/rs_pool.sv | 222 ++++++++++++++++++++++
 tb/tb_rs_pool.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_pool.sv
// rs_pool: reservation-station entry pool.
//
// Holds up to DEPTH ops that wait for their two source operands. Sources that
// are not ready at issue carry a producer tag and capture the value from the
// result broadcast bus when the tag matches. Entries whose sources are both
// ready are dispatched oldest-first; a DEPTH x DEPTH age matrix gives the order.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   flush_i              synchronous clear of every entry
//   issue_*              allocate one entry: payload plus per-source rdy/tag/value
//   bcast_*              result broadcast (valid, producer tag, value)
//   busy_o, count_o      pool full flag, number of occupied entries
//   dispatch_*           presented entry (valid/ready handshake, payload, operands)
module rs_pool #(
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 4,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         issue_en_i,
    input  logic [PAYLOAD_WIDTH-1:0]     issue_payload_i,
    input  logic                         issue_src1_rdy_i,
    input  logic                         issue_src2_rdy_i,
    input  logic [TAG_WIDTH-1:0]         issue_src1_tag_i,
    input  logic [TAG_WIDTH-1:0]         issue_src2_tag_i,
    input  logic [DATA_WIDTH-1:0]        issue_src1_val_i,
    input  logic [DATA_WIDTH-1:0]        issue_src2_val_i,
    input  logic                         bcast_valid_i,
    input  logic [TAG_WIDTH-1:0]         bcast_tag_i,
    input  logic [DATA_WIDTH-1:0]        bcast_value_i,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         dispatch_valid_o,
    input  logic                         dispatch_ready_i,
    output logic [PAYLOAD_WIDTH-1:0]     dispatch_payload_o,
    output logic [DATA_WIDTH-1:0]        dispatch_op1_o,
    output logic [DATA_WIDTH-1:0]        dispatch_op2_o
);

    localparam int CNT_W = $clog2(DEPTH+1);

    // Control state (reset): entry valid, per-source ready, age matrix.
    // age_q[i][j] = 1 means entry i was allocated before entry j.
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] rdy1_q;
    logic [DEPTH-1:0] rdy2_q;
    logic [DEPTH-1:0] age_q [DEPTH];

    // Data state (no reset): only observed through a valid entry.
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [TAG_WIDTH-1:0]     tag1_q    [DEPTH];
    logic [TAG_WIDTH-1:0]     tag2_q    [DEPTH];
    logic [DATA_WIDTH-1:0]    val1_q    [DEPTH];
    logic [DATA_WIDTH-1:0]    val2_q    [DEPTH];

    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] rdy1_d;
    logic [DEPTH-1:0] rdy2_d;
    logic [DEPTH-1:0] age_d [DEPTH];

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;
    logic             accept;
    logic             fire;
    logic             byp1;
    logic             byp2;

    // Occupancy and full flag, purely from registered valid bits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CNT_W'(vld_q[i]);
        end
    end

    assign busy_o = (count_o == CNT_W'(DEPTH));
    assign accept = issue_en_i && !busy_o;

    // Eligibility uses registered ready bits only, so a wakeup reaches
    // dispatch one cycle later and there is no bcast-to-dispatch path.
    assign eligible = vld_q & rdy1_q & rdy2_q;

    // Oldest eligible entry: no other eligible entry is older than it.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic older;
            older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && age_q[j][i]) begin
                    older = 1'b1;
                end
            end
            sel_oh[i] = eligible[i] && !older;
        end
    end

    assign dispatch_valid_o = |eligible;
    assign fire             = dispatch_valid_o && dispatch_ready_i;

    // sel_oh is zero whenever nothing is valid (including during reset),
    // which forces the dispatch data outputs to zero.
    always_comb begin
        dispatch_payload_o = '0;
        dispatch_op1_o     = '0;
        dispatch_op2_o     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                dispatch_payload_o = payload_q[i];
                dispatch_op1_o     = val1_q[i];
                dispatch_op2_o     = val2_q[i];
            end
        end
    end

    // Lowest-index free entry, from registered state: an entry freed by a
    // dispatch this cycle becomes available next cycle.
    always_comb begin
        logic found;
        alloc_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!vld_q[i] && !found) begin
                alloc_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    // Wakeup of waiting sources in valid entries; one broadcast may wake many.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake1[i] = bcast_valid_i && vld_q[i] && !rdy1_q[i] && (tag1_q[i] == bcast_tag_i);
            wake2[i] = bcast_valid_i && vld_q[i] && !rdy2_q[i] && (tag2_q[i] == bcast_tag_i);
        end
    end

    // Same-cycle bypass for a source being issued not ready.
    assign byp1 = !issue_src1_rdy_i && bcast_valid_i && (issue_src1_tag_i == bcast_tag_i);
    assign byp2 = !issue_src2_rdy_i && bcast_valid_i && (issue_src2_tag_i == bcast_tag_i);

    // Control next state; flush overrides issue, wakeup and dispatch.
    always_comb begin
        vld_d  = vld_q;
        rdy1_d = rdy1_q | wake1;
        rdy2_d = rdy2_q | wake2;
        age_d  = age_q;
        if (fire) begin
            vld_d = vld_d & ~sel_oh;
        end
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    vld_d[i]  = 1'b1;
                    rdy1_d[i] = issue_src1_rdy_i || byp1;
                    rdy2_d[i] = issue_src2_rdy_i || byp2;
                    // New entry is younger than every other entry.
                    age_d[i]  = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != i) begin
                            age_d[j][i] = 1'b1;
                        end
                    end
                end
            end
        end
        if (flush_i) begin
            vld_d  = '0;
            rdy1_d = '0;
            rdy2_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            age_q  <= age_d;
        end
    end

    // Entry data: written on allocation, operand values also on wakeup.
    // Allocation targets a free entry and wakeup only valid ones, so they
    // never hit the same entry in one cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && alloc_oh[i]) begin
                payload_q[i] <= issue_payload_i;
                tag1_q[i]    <= issue_src1_tag_i;
                tag2_q[i]    <= issue_src2_tag_i;
                val1_q[i]    <= issue_src1_rdy_i ? issue_src1_val_i : bcast_value_i;
                val2_q[i]    <= issue_src2_rdy_i ? issue_src2_val_i : bcast_value_i;
            end else begin
                if (wake1[i]) begin
                    val1_q[i] <= bcast_value_i;
                end
                if (wake2[i]) begin
                    val2_q[i] <= bcast_value_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_pool.sv
// Testbench for rs_pool: directed scenarios followed by randomized traffic,
// checked against an issue-ordered queue model of the pool. Dispatches the
// model expects are queued in a scoreboard; a monitor pops and compares them
// whenever the DUT completes a dispatch handshake.
module tb_rs_pool;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          issue_en_i;
    logic [PW-1:0] issue_payload_i;
    logic          issue_src1_rdy_i, issue_src2_rdy_i;
    logic [TW-1:0] issue_src1_tag_i, issue_src2_tag_i;
    logic [DW-1:0] issue_src1_val_i, issue_src2_val_i;
    logic          bcast_valid_i;
    logic [TW-1:0] bcast_tag_i;
    logic [DW-1:0] bcast_value_i;
    logic          busy_o;
    logic [CW-1:0] count_o;
    logic          dispatch_valid_o;
    logic          dispatch_ready_i;
    logic [PW-1:0] dispatch_payload_o;
    logic [DW-1:0] dispatch_op1_o, dispatch_op2_o;

    rs_pool #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .issue_en_i(issue_en_i), .issue_payload_i(issue_payload_i),
        .issue_src1_rdy_i(issue_src1_rdy_i), .issue_src2_rdy_i(issue_src2_rdy_i),
        .issue_src1_tag_i(issue_src1_tag_i), .issue_src2_tag_i(issue_src2_tag_i),
        .issue_src1_val_i(issue_src1_val_i), .issue_src2_val_i(issue_src2_val_i),
        .bcast_valid_i(bcast_valid_i), .bcast_tag_i(bcast_tag_i),
        .bcast_value_i(bcast_value_i),
        .busy_o(busy_o), .count_o(count_o),
        .dispatch_valid_o(dispatch_valid_o), .dispatch_ready_i(dispatch_ready_i),
        .dispatch_payload_o(dispatch_payload_o),
        .dispatch_op1_o(dispatch_op1_o), .dispatch_op2_o(dispatch_op2_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] payload;
        bit            r1, r2;
        logic [TW-1:0] t1, t2;
        logic [DW-1:0] v1, v2;
    } ent_t;

    typedef struct {
        logic [PW-1:0] payload;
        logic [DW-1:0] op1, op2;
    } exp_t;

    ent_t mq[$];    // model pool, oldest entry first
    exp_t sbq[$];   // expected dispatches

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle: called at a falling edge, drives inputs, checks the
    // presented state against the model, then advances the model.
    task automatic step(input bit fl, input bit ie, input logic [PW-1:0] pl,
                        input bit r1, input logic [TW-1:0] t1, input logic [DW-1:0] v1,
                        input bit r2, input logic [TW-1:0] t2, input logic [DW-1:0] v2,
                        input bit bv, input logic [TW-1:0] bt, input logic [DW-1:0] bval,
                        input bit rdy);
        int   k;
        bit   full;
        ent_t e;
        flush_i = fl; issue_en_i = ie; issue_payload_i = pl;
        issue_src1_rdy_i = r1; issue_src1_tag_i = t1; issue_src1_val_i = v1;
        issue_src2_rdy_i = r2; issue_src2_tag_i = t2; issue_src2_val_i = v2;
        bcast_valid_i = bv; bcast_tag_i = bt; bcast_value_i = bval;
        dispatch_ready_i = rdy;
        #1;
        k = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
        end
        full = (mq.size() == DEPTH);
        check("count", 64'(count_o), 64'(mq.size()));
        check("busy", 64'(busy_o), 64'(full));
        check("dispatch_valid", 64'(dispatch_valid_o), 64'(k >= 0));
        if (k >= 0) begin
            check("presented_payload", 64'(dispatch_payload_o), 64'(mq[k].payload));
            check("presented_op1", dispatch_op1_o, mq[k].v1);
            check("presented_op2", dispatch_op2_o, mq[k].v2);
            if (rdy) sbq.push_back('{mq[k].payload, mq[k].v1, mq[k].v2});
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (bv) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].r1 && mq[i].t1 == bt) begin mq[i].r1 = 1; mq[i].v1 = bval; end
                    if (!mq[i].r2 && mq[i].t2 == bt) begin mq[i].r2 = 1; mq[i].v2 = bval; end
                end
            end
            if (k >= 0 && rdy) mq.delete(k);
            if (ie && !full) begin
                e.payload = pl; e.t1 = t1; e.t2 = t2;
                e.r1 = r1 || (bv && t1 == bt);
                e.r2 = r2 || (bv && t2 == bt);
                e.v1 = r1 ? v1 : bval;
                e.v2 = r2 ? v2 : bval;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, '0, 1, '0, '0, 1, '0, '0, 0, '0, '0, rdy);
    endtask

    task automatic bcast(input logic [TW-1:0] t, input logic [DW-1:0] v, input bit rdy);
        step(0, 0, '0, 1, '0, '0, 1, '0, '0, 1, t, v, rdy);
    endtask

    task automatic iss_ready(input logic [PW-1:0] pl, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input bit rdy);
        step(0, 1, pl, 1, '0, a, 1, '0, b, 0, '0, '0, rdy);
    endtask

    task automatic check_zero_outputs(input string tagname);
        check({tagname, "_busy"}, 64'(busy_o), 64'd0);
        check({tagname, "_count"}, 64'(count_o), 64'd0);
        check({tagname, "_dvalid"}, 64'(dispatch_valid_o), 64'd0);
        check({tagname, "_payload"}, 64'(dispatch_payload_o), 64'd0);
        check({tagname, "_op1"}, dispatch_op1_o, 64'd0);
        check({tagname, "_op2"}, dispatch_op2_o, 64'd0);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must drop at once.
    task automatic mid_reset();
        flush_i = 0; issue_en_i = 0; bcast_valid_i = 0; dispatch_ready_i = 0;
        #3;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
    endtask

    // Scoreboard monitor: compares every completed dispatch handshake.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && dispatch_valid_o && dispatch_ready_i) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_dispatch", 64'(dispatch_payload_o), 64'hDEAD);
                end else begin
                    x = sbq.pop_front();
                    check("sb_payload", 64'(dispatch_payload_o), 64'(x.payload));
                    check("sb_op1", dispatch_op1_o, x.op1);
                    check("sb_op2", dispatch_op2_o, x.op2);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        flush_i = 0; issue_en_i = 0; issue_payload_i = '0;
        issue_src1_rdy_i = 0; issue_src2_rdy_i = 0;
        issue_src1_tag_i = '0; issue_src2_tag_i = '0;
        issue_src1_val_i = '0; issue_src2_val_i = '0;
        bcast_valid_i = 0; bcast_tag_i = '0; bcast_value_i = '0;
        dispatch_ready_i = 0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Ready issue: dispatches the next cycle with op1=5, op2=7.
        iss_ready(32'hA, 64'd5, 64'd7, 1);
        idle(1);
        idle(1);

        // Wakeup: src2 waits on tag 3, broadcast two cycles later.
        step(0, 1, 32'hB, 1, '0, 64'h11, 0, 4'd3, '0, 0, '0, '0, 1);
        idle(1);
        bcast(4'd3, 64'h99, 1);
        idle(1);
        idle(1);

        // Bypass: src1 tag 2 issued while tag 2 is broadcast.
        step(0, 1, 32'hC, 0, 4'd2, '0, 1, '0, 64'h22, 1, 4'd2, 64'h42, 1);
        idle(1);
        idle(1);

        // Full/ordering: four entries wait on tag 1; fifth issue ignored.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, PW'(32'h100 + i), 0, 4'd1, '0, 1, '0, DW'(i), 0, '0, '0, 1);
        end
        bcast(4'd1, 64'h77, 1);
        for (int i = 0; i < 5; i++) idle(1);

        // Unmatched broadcast has no effect.
        step(0, 1, 32'hD, 0, 4'd5, '0, 1, '0, 64'h5, 0, '0, '0, 0);
        bcast(4'd6, 64'hBAD, 0);
        idle(0);

        // Backpressure then simultaneous issue and dispatch.
        iss_ready(32'hE0, 64'h1, 64'h2, 0);
        iss_ready(32'hE1, 64'h3, 64'h4, 0);
        idle(0);
        idle(0);
        idle(0);
        iss_ready(32'hE2, 64'h5, 64'h6, 1);
        bcast(4'd5, 64'h55, 1);
        for (int i = 0; i < 5; i++) idle(1);

        // Flush with three entries, then reset mid-operation.
        for (int i = 0; i < 3; i++) iss_ready(PW'(32'hF0 + i), DW'(i), DW'(i + 1), 0);
        step(1, 0, '0, 1, '0, '0, 1, '0, '0, 0, '0, '0, 0);
        idle(0);
        for (int i = 0; i < 3; i++) iss_ready(PW'(32'hF8 + i), DW'(i), DW'(i + 2), 0);
        mid_reset();
        iss_ready(32'h1234, 64'hAB, 64'hCD, 1);
        idle(1);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 149) begin
                mid_reset();
            end else begin
                step($urandom_range(0, 39) == 0,
                     $urandom_range(0, 1) == 1, $urandom(),
                     $urandom_range(0, 1) == 1, TW'($urandom_range(0, 3)), {$urandom(), $urandom()},
                     $urandom_range(0, 1) == 1, TW'($urandom_range(0, 3)), {$urandom(), $urandom()},
                     $urandom_range(0, 1) == 1, TW'($urandom_range(0, 5)), {$urandom(), $urandom()},
                     $urandom_range(0, 9) < 7);
            end
        end

        // Drain: broadcast every tag in turn until the model is empty.
        for (int n = 0; n < 60 && mq.size() != 0; n++) begin
            bcast(TW'(n % 4), {$urandom(), $urandom()}, 1);
        end
        idle(1);
        idle(1);
        #3;
        check("sb_drained", 64'(sbq.size()), 64'd0);
        check("model_drained", 64'(mq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
